mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the pipeline memory stage. It sits between EXE and WB and is clocked. It accepts one load/store/pass-through op per handshake and generates byte-lane enables and lane-aligned store data. It drives a request/grant/response memory port, with a timeout, and returns sign/zero-extended load results with an exception code.
Single outstanding access; EXE and WB sides use valid/ready handshakes.

Parameters:
XLEN, 32, datapath width; 32 or 64.
ADDR_W, 10, byte address width.
WB_W, 11, width of writeback pass-through field.
TIMEOUT, 15, max cycles in WAIT before bus-error (>=1).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EXE op valid
in_ready  out  1  unit can accept op
in_read  in  1  load
in_write  in  1  store (read&write both set = illegal -> exception 3)
in_len  in  2  0 byte, 1 half, 2 word, 3 dword (legal only XLEN=64)
in_un  in  1  unsigned load
in_wb  in  WB_W  writeback pass-through
in_addr  in  ADDR_W  byte address
in_data  in  XLEN  exe result / store data (low bits)
mem_req  out  1  access request
mem_we  out  1  write
mem_be  out  XLEN/8  byte enables
mem_addr  out  ADDR_W-log2(XLEN/8)  word address
mem_wdata  out  XLEN  lane-aligned store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read word
out_valid  out  1  result valid to WB
out_ready  in  1  WB accepts
out_wb  out  WB_W  registered pass-through
out_result  out  XLEN  load result or in_data
out_exc  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal op

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset: state IDLE; all outputs 0 except in_ready=1.
- in_ready = (state==IDLE). Accept on in_valid&in_ready rising edge; capture all in_* into registers.
- Alignment check: addr mod (1<<in_len) != 0 -> misaligned. in_len=3 with XLEN=32 -> illegal.
- Accept, no read/write, or exception -> RESP next cycle. out_result=in_data for pass-through, 0 for exception. No mem_req ever issued for an excepted op.
- Accept, legal read/write -> REQ. mem_req=1 with stable mem_we/mem_be/mem_addr/mem_wdata until mem_gnt sampled high.
- mem_be: (2^(1<<len))-1 shifted left by addr low bits. mem_wdata: in_data low (8<<len) bits replicated across the word.
- REQ & gnt & write -> RESP (exc 0). REQ & gnt & read -> WAIT; clear timeout counter.
- WAIT: mem_rvalid -> capture extracted lane into out_result -> RESP. Extraction: shift right by 8*addr_low, keep 8<<len bits, extend with ~un & msb. Word on XLEN=64 with un=0 is sign-extended.
- Counter increments each WAIT cycle without rvalid. Reaching TIMEOUT -> RESP with exc=2, out_result=0. A later stray rvalid is ignored in all non-WAIT states.
- mem_rvalid is never asserted in the same cycle as the granting mem_gnt; the earliest is the next cycle.
- RESP: out_valid=1, outputs held stable until out_ready. Then IDLE. No new accept in the same cycle (min 1 bubble).
- Min latency accept->out_valid: 1 cycle for pass-through; 2 for store with immediate gnt; 3 for load with gnt+1 rvalid.
- Async reset mid-operation: immediately IDLE, mem_req=0, out_valid=0; the in-flight op is dropped.

Decomposition:
- Package mem_access_pkg: len encodings, exception codes, state enum, lane-count function.
- Sub-module mem_lane_extract: combinational load-lane extraction and sign/zero extension, parameterised by XLEN. Reused by future cache path.

Test Plan:
- Pass-through: read=write=0, in_data=0x1234_5678, wb=0x155 -> out_valid next cycle, out_result=0x12345678, exc=0.
- Signed byte load addr=0x003, rdata=0x80FF_0102 -> mem_be=4'b1000, addr word 0x000, out_result=0xFFFF_FF80. Same with un=1 -> 0x0000_0080.
- Half store addr=0x006, in_data=0xABCD -> mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1. With gnt delayed 3 cycles, mem_req stays high with stable fields.
- Misaligned word load addr=0x002 -> no mem_req, exc=1, out_valid next cycle. len=3 on XLEN=32 -> exc=3.
- Load with no rvalid -> after TIMEOUT=15 WAIT cycles exc=2. A stray rvalid afterwards causes no effect.
- out_ready held low 5 cycles in RESP -> outputs stable, in_ready=0. Reset asserted in WAIT -> IDLE, mem_req=0, out_valid=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access stage: access lengths, exception
// codes, FSM states and a lane-count helper.
package mem_access_pkg;

  typedef enum logic [1:0] {
    LEN_B = 2'd0,
    LEN_H = 2'd1,
    LEN_W = 2'd2,
    LEN_D = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_TIMEOUT  = 2'd2,
    EXC_ILLEGAL  = 2'd3
  } exc_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Number of byte lanes in a datapath word.
  function automatic int unsigned lanes(input int unsigned xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Load-lane extraction: pulls the addressed byte/half/word/dword out of a
// read word and sign- or zero-extends it to XLEN. Purely combinational.
module mem_lane_extract
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]                     rdata_i,
  input  logic [$clog2(lanes(XLEN))-1:0]      off_i,
  input  logic [1:0]                          len_i,
  input  logic                                un_i,
  output logic [XLEN-1:0]                     result_o
);

  localparam logic [7:0] XB = 8'(XLEN);

  logic [7:0]      nbits;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] top;
  logic            sext;

  // Align the lane to bit 0, mask to the access width, extend from its msb.
  // The msb is found via the top bit of the mask to avoid a variable index.
  always_comb begin
    nbits = 8'd8 << len_i;
    if (nbits > XB) nbits = XB;
    shifted  = rdata_i >> {off_i, 3'b000};
    mask     = (nbits == XB) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    top      = mask & ~(mask >> 1);
    sext     = ~un_i & (|(shifted & top));
    result_o = (shifted & mask) | ({XLEN{sext}} & ~mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage between EXE and WB. One op in flight: pass-through,
// load or store. Drives a req/gnt/rvalid memory port with a response
// timeout and returns extended load data plus an exception code.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 10,
  parameter int WB_W    = 11,
  parameter int TIMEOUT = 15
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_read,
  input  logic                                  in_write,
  input  logic [1:0]                            in_len,
  input  logic                                  in_un,
  input  logic [WB_W-1:0]                       in_wb,
  input  logic [ADDR_W-1:0]                     in_addr,
  input  logic [XLEN-1:0]                       in_data,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [XLEN/8-1:0]                     mem_be,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0]      mem_addr,
  output logic [XLEN-1:0]                       mem_wdata,
  input  logic                                  mem_gnt,
  input  logic                                  mem_rvalid,
  input  logic [XLEN-1:0]                       mem_rdata,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WB_W-1:0]                       out_wb,
  output logic [XLEN-1:0]                       out_result,
  output logic [1:0]                            out_exc
);

  localparam int NB    = lanes(XLEN);
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [1:0]        len;
    logic              un;
    logic [WB_W-1:0]   wb;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } op_t;

  state_e          state_q, state_d;
  op_t             op_q, op_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [1:0]      exc_q, exc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [1:0]       exc_in;
  logic [OFF_W-1:0] in_amask;
  logic [OFF_W-1:0] op_amask;
  logic [15:0]      be_base;
  logic [NB-1:0]    be;
  logic [XLEN-1:0]  ld_res;
  logic [NB-1:0][7:0] data_bytes;
  logic [NB-1:0][7:0] wdata_bytes;

  assign accept = in_valid & (state_q == S_IDLE);

  // Classify the incoming op; illegal beats misaligned. Alignment only
  // matters for ops that actually touch memory.
  always_comb begin
    in_amask = OFF_W'((4'd1 << in_len) - 4'd1);
    exc_in   = EXC_NONE;
    if (in_read & in_write)
      exc_in = EXC_ILLEGAL;
    else if ((in_read | in_write) && (in_len == LEN_D) && (XLEN < 64))
      exc_in = EXC_ILLEGAL;
    else if ((in_read | in_write) && ((in_addr[OFF_W-1:0] & in_amask) != '0))
      exc_in = EXC_MISALIGN;
  end

  // Byte enables: a run of 2^len ones starting at the addressed lane.
  always_comb begin
    be_base = (16'd1 << (5'd1 << op_q.len)) - 16'd1;
    be      = NB'(be_base) << op_q.addr[OFF_W-1:0];
    op_amask = OFF_W'((4'd1 << op_q.len) - 4'd1);
  end

  // Store data replication: lane b carries source byte (b mod 2^len).
  assign data_bytes = op_q.data;
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [OFF_W-1:0] src;
    assign src            = OFF_W'(b) & op_amask;
    assign wdata_bytes[b] = data_bytes[src];
  end

  mem_lane_extract #(.XLEN(XLEN)) u_extract (
    .rdata_i  (mem_rdata),
    .off_i    (op_q.addr[OFF_W-1:0]),
    .len_i    (op_q.len),
    .un_i     (op_q.un),
    .result_o (ld_res)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if ((exc_in != EXC_NONE) || !(in_read | in_write)) state_d = S_RESP;
        else                                               state_d = S_REQ;
      end
      S_REQ:  if (mem_gnt) state_d = op_q.wr ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid || (cnt_q == CNT_W'(TIMEOUT - 1))) state_d = S_RESP;
      S_RESP: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; memory fields are only driven while requesting.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_RESP);
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req & op_q.wr;
    mem_be    = mem_req ? be : '0;
    mem_addr  = mem_req ? op_q.addr[ADDR_W-1:OFF_W] : '0;
    mem_wdata = mem_req ? XLEN'(wdata_bytes) : '0;
  end

  assign out_wb     = op_q.wb;
  assign out_result = res_q;
  assign out_exc    = exc_q;

  // Datapath next state: capture on accept, load data / timeout in WAIT.
  always_comb begin
    op_d  = op_q;
    res_d = res_q;
    exc_d = exc_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d.rd   = in_read;
        op_d.wr   = in_write;
        op_d.len  = in_len;
        op_d.un   = in_un;
        op_d.wb   = in_wb;
        op_d.addr = in_addr;
        op_d.data = in_data;
        exc_d     = exc_in;
        res_d     = (exc_in == EXC_NONE) ? in_data : '0;
        cnt_d     = '0;
      end
      S_REQ: if (mem_gnt) cnt_d = '0;
      S_WAIT: begin
        if (mem_rvalid) begin
          res_d = ld_res;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d = '0;
          exc_d = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      res_q <= '0;
      exc_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      res_q <= res_d;
      exc_q <= exc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32, TIMEOUT=15).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_read = 1'b0, in_write = 1'b0, in_un = 1'b0;
  logic [1:0]  in_len = 2'd0;
  logic [10:0] in_wb = '0;
  logic [9:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [10:0] out_wb;
  logic [31:0] out_result;
  logic [1:0]  out_exc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .ADDR_W(10), .WB_W(11), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_read(in_read), .in_write(in_write),
    .in_len(in_len), .in_un(in_un), .in_wb(in_wb), .in_addr(in_addr), .in_data(in_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb(out_wb),
    .out_result(out_result), .out_exc(out_exc)
  );

  // Present one op for one cycle; returns at posedge+1 after the accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] len, input logic un,
                       input logic [9:0] addr, input logic [31:0] data, input logic [10:0] wb);
    in_valid = 1'b1; in_read = rd; in_write = wr; in_len = len; in_un = un;
    in_addr = addr; in_data = data; in_wb = wb;
    @(posedge clk); #1;
    in_valid = 1'b0; in_read = 1'b0; in_write = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if ({out_result, out_exc, out_wb} !== '0) begin bad++; $display("FAIL reset_outs got=%h/%h/%h exp=0", out_result, out_exc, out_wb); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    issue(1'b0, 1'b0, 2'd2, 1'b0, 10'h000, 32'h1234_5678, 11'h155);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pt_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== 32'h1234_5678) begin bad++; $display("FAIL pt_result got=%h exp=12345678", out_result); end
    total++; if (out_wb !== 11'h155) begin bad++; $display("FAIL pt_wb got=%h exp=155", out_wb); end
    total++; if (out_exc !== 2'd0) begin bad++; $display("FAIL pt_exc got=%0d exp=0", out_exc); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL pt_no_req got=%b exp=0", mem_req); end
    drain();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL pt_idle got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_load(input logic [1:0] len, input logic un, input logic [9:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [7:0] exp_wa, input logic [31:0] exp_res);
    issue(1'b1, 1'b0, len, un, addr, 32'h0, 11'h0aa);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL ld_req a=%h got=%b/%b exp=1/0", addr, mem_req, mem_we); end
    total++; if (mem_be !== exp_be) begin bad++; $display("FAIL ld_be a=%h got=%b exp=%b", addr, mem_be, exp_be); end
    total++; if (mem_addr !== exp_wa) begin bad++; $display("FAIL ld_addr a=%h got=%h exp=%h", addr, mem_addr, exp_wa); end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    total++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL ld_wait a=%h got=%b/%b exp=0/0", addr, mem_req, out_valid); end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ld_valid a=%h got=%b exp=1", addr, out_valid); end
    total++; if (out_result !== exp_res || out_exc !== 2'd0) begin bad++; $display("FAIL ld_result a=%h got=%h/%0d exp=%h/0", addr, out_result, out_exc, exp_res); end
    drain();
  endtask

  task automatic test_store_half();
    issue(1'b0, 1'b1, 2'd1, 1'b0, 10'h006, 32'h0000_ABCD, 11'h033);
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 ||
                   mem_addr !== 8'h01 || mem_wdata !== 32'hABCD_ABCD) begin
        bad++; $display("FAIL st_fields cyc=%0d got=%b/%b/%b/%h/%h exp=1/1/1100/01/abcdabcd",
                        i, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      if (i == 3) mem_gnt = 1'b1;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    total++; if (out_valid !== 1'b1 || out_exc !== 2'd0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL st_resp got=%b/%0d/%b exp=1/0/0", out_valid, out_exc, mem_req);
    end
    drain();
  endtask

  task automatic test_exceptions();
    // misaligned word load
    issue(1'b1, 1'b0, 2'd2, 1'b0, 10'h002, 32'h1111_1111, 11'h0);
    total++; if (mem_req !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL mis_w_seq got=%b/%b exp=0/1", mem_req, out_valid); end
    total++; if (out_exc !== 2'd1 || out_result !== 32'h0) begin bad++; $display("FAIL mis_w_exc got=%0d/%h exp=1/0", out_exc, out_result); end
    drain();
    // misaligned half store
    issue(1'b0, 1'b1, 2'd1, 1'b0, 10'h005, 32'h2222_2222, 11'h0);
    total++; if (mem_req !== 1'b0 || out_exc !== 2'd1) begin bad++; $display("FAIL mis_h_exc got=%b/%0d exp=0/1", mem_req, out_exc); end
    drain();
    // dword on a 32-bit datapath
    issue(1'b1, 1'b0, 2'd3, 1'b0, 10'h000, 32'h3333_3333, 11'h0);
    total++; if (mem_req !== 1'b0 || out_exc !== 2'd3 || out_result !== 32'h0) begin bad++; $display("FAIL ill_len got=%b/%0d/%h exp=0/3/0", mem_req, out_exc, out_result); end
    drain();
    // read and write together
    issue(1'b1, 1'b1, 2'd2, 1'b0, 10'h000, 32'h4444_4444, 11'h0);
    total++; if (mem_req !== 1'b0 || out_exc !== 2'd3) begin bad++; $display("FAIL ill_rw got=%b/%0d exp=0/3", mem_req, out_exc); end
    drain();
  endtask

  task automatic test_timeout();
    issue(1'b1, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 11'h0);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_exc !== 2'd2 || out_result !== 32'h0) begin
      bad++; $display("FAIL to_resp got=%b/%0d/%h exp=1/2/0", out_valid, out_exc, out_result);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_exc !== 2'd2 || out_result !== 32'h0) begin
      bad++; $display("FAIL to_stray_resp got=%b/%0d/%h exp=1/2/0", out_valid, out_exc, out_result);
    end
    drain();
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL to_stray_idle got=%b/%b/%b exp=1/0/0", in_ready, out_valid, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_read = 1'b0; in_write = 1'b0; in_len = 2'd2;
    in_addr = 10'h0; in_data = 32'hCAFE_0001; in_wb = 11'h101;
    @(posedge clk); #1;
    in_data = 32'hCAFE_0002; in_wb = 11'h202;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'hCAFE_0001 || out_wb !== 11'h101) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h/%h exp=1/0/cafe0001/101", i, out_valid, in_ready, out_result, out_wb);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_bubble got=%b/%b exp=1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'hCAFE_0002 || out_wb !== 11'h202) begin
      bad++; $display("FAIL bp_second got=%b/%h/%h exp=1/cafe0002/202", out_valid, out_result, out_wb);
    end
    drain();
  endtask

  task automatic test_reset_wait();
    issue(1'b1, 1'b0, 2'd0, 1'b0, 10'h001, 32'h0, 11'h0);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_wait got=%b/%b/%b exp=0/0/1", mem_req, out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_after got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load(2'd0, 1'b0, 10'h003, 32'h80FF_0102, 4'b1000, 8'h00, 32'hFFFF_FF80);
    test_load(2'd0, 1'b1, 10'h003, 32'h80FF_0102, 4'b1000, 8'h00, 32'h0000_0080);
    test_load(2'd1, 1'b0, 10'h00A, 32'h8001_1234, 4'b1100, 8'h02, 32'hFFFF_8001);
    test_load(2'd0, 1'b0, 10'h011, 32'h1234_7F56, 4'b0010, 8'h04, 32'h0000_007F);
    test_load(2'd2, 1'b0, 10'h3FC, 32'h89AB_CDEF, 4'b1111, 8'hFF, 32'h89AB_CDEF);
    test_store_half();
    test_exceptions();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
